// File: rtl/cpu_run_ctrl_if.sv
// Debug/pipeline-side signal bundle of the run controller.
// master = debug host + pipeline (drives requests/status), slave = cpu_run_ctrl.
interface cpu_run_ctrl_if #(
    parameter int CNT_W = 32
);
    logic             run_req;
    logic             step_req;
    logic             halt_req;
    logic             clear_req;
    logic             bp_en;
    logic [15:0]      bp_addr;
    logic [15:0]      pc_addr;
    logic             hazard_stall;
    logic             halt_instr;
    logic             div0;
    logic             overflow;
    logic             core_rst;
    logic             freeze;
    logic [2:0]       state;
    logic [2:0]       halt_cause;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] retired_cnt;

    modport master (
        output run_req, step_req, halt_req, clear_req, bp_en, bp_addr, pc_addr,
               hazard_stall, halt_instr, div0, overflow,
        input  core_rst, freeze, state, halt_cause, cycle_cnt, retired_cnt
    );

    modport slave (
        input  run_req, step_req, halt_req, clear_req, bp_en, bp_addr, pc_addr,
               hazard_stall, halt_instr, div0, overflow,
        output core_rst, freeze, state, halt_cause, cycle_cnt, retired_cnt
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/halt/step sequencer for the 16-bit core: core reset release, breakpoint and
// single-step debug, div0/overflow fault capture, cycle and retired counters.
//
// state      | meaning
// RESET_HOLD | core_rst and freeze asserted for RST_HOLD_CYCLES cycles
// HALTED     | frozen, waiting for run_req or step_req
// RUN        | free running, watching faults, halt opcode, breakpoint, halt_req
// STEP       | running until one instruction leaves stage 1
// FAULT      | frozen after div0/overflow until clear_req
module cpu_run_ctrl #(
    parameter int RST_HOLD_CYCLES = 4,
    parameter bit AUTO_RUN        = 1'b1,
    parameter int CNT_W           = 32
) (
    input logic           clk,
    input logic           rst_n,
    cpu_run_ctrl_if.slave bus
);

    localparam logic [2:0] S_RESET_HOLD = 3'd0;
    localparam logic [2:0] S_HALTED     = 3'd1;
    localparam logic [2:0] S_RUN        = 3'd2;
    localparam logic [2:0] S_STEP       = 3'd3;
    localparam logic [2:0] S_FAULT      = 3'd4;

    localparam logic [2:0] C_NONE       = 3'd0;
    localparam logic [2:0] C_HALT_REQ   = 3'd1;
    localparam logic [2:0] C_STEP       = 3'd2;
    localparam logic [2:0] C_BP         = 3'd3;
    localparam logic [2:0] C_DIV0       = 3'd4;
    localparam logic [2:0] C_OVF        = 3'd5;
    localparam logic [2:0] C_HALT_INSTR = 3'd6;

    localparam int                HOLD_W    = (RST_HOLD_CYCLES > 1) ? $clog2(RST_HOLD_CYCLES) : 1;
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

    logic [2:0]        state_q, next_state;
    logic [2:0]        cause_q, next_cause;
    logic              skip_q, next_skip;
    logic [HOLD_W-1:0] hold_q;
    logic              core_rst_q, freeze_q;
    logic [CNT_W-1:0]  cycle_q, retired_q;
    logic              bp_hit;
    logic              active;

    assign bp_hit = bus.bp_en && (bus.pc_addr == bus.bp_addr) && !skip_q;
    assign active = (state_q == S_RUN) || (state_q == S_STEP);

    always_comb begin
        next_state = state_q;
        next_cause = cause_q;
        next_skip  = skip_q;
        case (state_q)
            S_RESET_HOLD: begin
                next_skip = 1'b0;
                if (hold_q == HOLD_LAST) begin
                    next_state = AUTO_RUN ? S_RUN : S_HALTED;
                    next_cause = C_NONE;
                end
            end
            S_HALTED: begin
                if (bus.run_req) begin
                    next_state = S_RUN;
                    next_cause = C_NONE;
                    next_skip  = 1'b1;
                end else if (bus.step_req) begin
                    next_state = S_STEP;
                    next_cause = C_NONE;
                end
            end
            S_RUN: begin
                // the breakpoint PC we resumed from is masked until stage 1 advances once
                if (!bus.hazard_stall) next_skip = 1'b0;
                if (bus.div0) begin
                    next_state = S_FAULT;
                    next_cause = C_DIV0;
                end else if (bus.overflow) begin
                    next_state = S_FAULT;
                    next_cause = C_OVF;
                end else if (bus.halt_instr) begin
                    next_state = S_HALTED;
                    next_cause = C_HALT_INSTR;
                end else if (bp_hit) begin
                    next_state = S_HALTED;
                    next_cause = C_BP;
                end else if (bus.halt_req) begin
                    next_state = S_HALTED;
                    next_cause = C_HALT_REQ;
                end
            end
            S_STEP: begin
                if (bus.div0) begin
                    next_state = S_FAULT;
                    next_cause = C_DIV0;
                end else if (bus.overflow) begin
                    next_state = S_FAULT;
                    next_cause = C_OVF;
                end else if (bus.halt_instr) begin
                    next_state = S_HALTED;
                    next_cause = C_HALT_INSTR;
                end else if (!bus.hazard_stall) begin
                    next_state = S_HALTED;
                    next_cause = C_STEP;
                end
            end
            S_FAULT: begin
                if (bus.clear_req) next_state = S_RESET_HOLD;
            end
            default: begin
                next_state = S_RESET_HOLD;
                next_skip  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_RESET_HOLD;
            cause_q    <= C_NONE;
            skip_q     <= 1'b0;
            hold_q     <= '0;
            core_rst_q <= 1'b1;
            freeze_q   <= 1'b1;
            cycle_q    <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= next_state;
            cause_q    <= next_cause;
            skip_q     <= next_skip;
            core_rst_q <= (next_state == S_RESET_HOLD);
            freeze_q   <= (next_state == S_RESET_HOLD) || (next_state == S_HALTED) ||
                          (next_state == S_FAULT);
            hold_q     <= ((state_q == S_RESET_HOLD) && (next_state == S_RESET_HOLD)) ?
                          hold_q + HOLD_ONE : '0;
            if (state_q == S_RESET_HOLD) begin
                cycle_q   <= '0;
                retired_q <= '0;
            end else if (active) begin
                cycle_q <= cycle_q + CNT_ONE;
                if (!freeze_q && !bus.hazard_stall) retired_q <= retired_q + CNT_ONE;
            end
        end
    end

    assign bus.state       = state_q;
    assign bus.halt_cause  = cause_q;
    assign bus.core_rst    = core_rst_q;
    assign bus.freeze      = freeze_q;
    assign bus.cycle_cnt   = cycle_q;
    assign bus.retired_cnt = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Self-checking bench for cpu_run_ctrl: directed debug scenarios with randomized
// stalls, PCs and event mixes, expected values derived from the controller rules.
module tb_cpu_run_ctrl;

    localparam logic [2:0] ST_RESET_HOLD = 3'd0;
    localparam logic [2:0] ST_HALTED     = 3'd1;
    localparam logic [2:0] ST_RUN        = 3'd2;
    localparam logic [2:0] ST_STEP       = 3'd3;
    localparam logic [2:0] ST_FAULT      = 3'd4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic rst4_n = 1'b0;
    always #5 clk = ~clk;

    cpu_run_ctrl_if #(.CNT_W(32)) bus ();
    cpu_run_ctrl_if #(.CNT_W(4))  bus4 ();

    cpu_run_ctrl #(.RST_HOLD_CYCLES(4), .AUTO_RUN(1'b1), .CNT_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );
    cpu_run_ctrl #(.RST_HOLD_CYCLES(4), .AUTO_RUN(1'b1), .CNT_W(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .bus(bus4)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] e_cyc  = '0;
    logic [31:0] e_ret  = '0;
    bit          e_active = 1'b0;

    task automatic clear_inputs();
        bus.run_req = 0; bus.step_req = 0; bus.halt_req = 0; bus.clear_req = 0;
        bus.bp_en = 0; bus.bp_addr = 16'h0010; bus.pc_addr = 16'h0100;
        bus.hazard_stall = 0; bus.halt_instr = 0; bus.div0 = 0; bus.overflow = 0;
    endtask

    // one clock edge; expected counters advance when the cycle being closed is RUN/STEP
    task automatic tick();
        if (e_active) begin
            e_cyc = e_cyc + 1;
            if (!bus.hazard_stall) e_ret = e_ret + 1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.state !== ST_RESET_HOLD || bus.core_rst !== 1'b1 || bus.freeze !== 1'b1) begin
            errors++; $display("FAIL reset_outputs state=%0d core_rst=%b freeze=%b exp 0/1/1", bus.state, bus.core_rst, bus.freeze); end
        checks++; if (bus.halt_cause !== 3'd0 || bus.cycle_cnt !== 32'd0 || bus.retired_cnt !== 32'd0) begin
            errors++; $display("FAIL reset_regs cause=%0d cyc=%0d ret=%0d exp 0/0/0", bus.halt_cause, bus.cycle_cnt, bus.retired_cnt); end
        rst_n = 1; e_active = 0; e_cyc = 0; e_ret = 0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (bus.core_rst !== (i < 4)) begin
                errors++; $display("FAIL reset_hold_len cycle=%0d core_rst=%b exp %b", i, bus.core_rst, (i < 4)); end
        end
        checks++; if (bus.state !== ST_RUN || bus.freeze !== 1'b0) begin
            errors++; $display("FAIL reset_exit state=%0d freeze=%b exp 2/0", bus.state, bus.freeze); end
        e_active = 1;
        for (int i = 0; i < int'($urandom_range(6, 12)); i++) begin
            bus.hazard_stall = 1'($urandom_range(0, 1));
            tick();
        end
        bus.hazard_stall = 0;
        checks++; if (bus.cycle_cnt !== e_cyc || bus.retired_cnt !== e_ret) begin
            errors++; $display("FAIL reset_run_counts cyc=%0d ret=%0d exp %0d/%0d", bus.cycle_cnt, bus.retired_cnt, e_cyc, e_ret); end
    endtask

    task automatic test_breakpoint();
        logic [15:0] pc;
        bus.bp_addr = 16'h0010;
        bus.bp_en = 0; bus.pc_addr = 16'h0010;
        tick(); tick();
        checks++; if (bus.state !== ST_RUN) begin
            errors++; $display("FAIL bp_disabled state=%0d exp 2", bus.state); end
        bus.bp_en = 1;
        for (int i = 0; i < int'($urandom_range(3, 8)); i++) begin
            pc = 16'($urandom_range(0, 127)) << 1;
            if (pc == 16'h0010) pc = 16'h0020;
            bus.pc_addr = pc;
            bus.hazard_stall = 1'($urandom_range(0, 1));
            tick();
            checks++; if (bus.state !== ST_RUN) begin
                errors++; $display("FAIL bp_false_hit pc=%h state=%0d exp 2", pc, bus.state); end
        end
        bus.pc_addr = 16'h0010; bus.hazard_stall = 1'($urandom_range(0, 1));
        tick(); e_active = 0;
        checks++; if (bus.state !== ST_HALTED || bus.halt_cause !== 3'd3 || bus.freeze !== 1'b1) begin
            errors++; $display("FAIL bp_hit state=%0d cause=%0d freeze=%b exp 1/3/1", bus.state, bus.halt_cause, bus.freeze); end
        bus.hazard_stall = 0; bus.halt_req = 1; bus.clear_req = 1;
        tick(); tick();
        bus.halt_req = 0; bus.clear_req = 0;
        checks++; if (bus.state !== ST_HALTED || bus.cycle_cnt !== e_cyc || bus.retired_cnt !== e_ret) begin
            errors++; $display("FAIL bp_halted_idle state=%0d cyc=%0d ret=%0d exp 1/%0d/%0d", bus.state, bus.cycle_cnt, bus.retired_cnt, e_cyc, e_ret); end
        bus.run_req = 1;
        tick(); bus.run_req = 0; e_active = 1;
        checks++; if (bus.state !== ST_RUN || bus.halt_cause !== 3'd0 || bus.freeze !== 1'b0) begin
            errors++; $display("FAIL bp_resume state=%0d cause=%0d freeze=%b exp 2/0/0", bus.state, bus.halt_cause, bus.freeze); end
        bus.hazard_stall = 1; tick();
        bus.hazard_stall = 0; tick();
        checks++; if (bus.state !== ST_RUN) begin
            errors++; $display("FAIL bp_no_retrigger state=%0d exp 2", bus.state); end
        bus.pc_addr = 16'h0012; tick(); tick();
        checks++; if (bus.state !== ST_RUN || bus.cycle_cnt !== e_cyc || bus.retired_cnt !== e_ret) begin
            errors++; $display("FAIL bp_resume_counts state=%0d cyc=%0d ret=%0d exp 2/%0d/%0d", bus.state, bus.cycle_cnt, bus.retired_cnt, e_cyc, e_ret); end
        bus.pc_addr = 16'h0010; tick(); e_active = 0;
        checks++; if (bus.state !== ST_HALTED || bus.halt_cause !== 3'd3) begin
            errors++; $display("FAIL bp_rearmed state=%0d cause=%0d exp 1/3", bus.state, bus.halt_cause); end
        bus.bp_en = 0; bus.pc_addr = 16'h0040;
    endtask

    task automatic test_step();
        logic [31:0] base_c, base_r;
        int k;
        bus.step_req = 1; bus.hazard_stall = 1;
        tick(); bus.step_req = 0; e_active = 1;
        base_c = e_cyc; base_r = e_ret;
        checks++; if (bus.state !== ST_STEP || bus.halt_cause !== 3'd0 || bus.freeze !== 1'b0) begin
            errors++; $display("FAIL step_enter state=%0d cause=%0d freeze=%b exp 3/0/0", bus.state, bus.halt_cause, bus.freeze); end
        tick(); tick();
        checks++; if (bus.state !== ST_STEP) begin
            errors++; $display("FAIL step_hold state=%0d exp 3", bus.state); end
        bus.hazard_stall = 0; tick(); e_active = 0;
        checks++; if (bus.state !== ST_HALTED || bus.halt_cause !== 3'd2 || bus.freeze !== 1'b1) begin
            errors++; $display("FAIL step_done state=%0d cause=%0d freeze=%b exp 1/2/1", bus.state, bus.halt_cause, bus.freeze); end
        checks++; if (bus.cycle_cnt !== base_c + 32'd3 || bus.retired_cnt !== base_r + 32'd1) begin
            errors++; $display("FAIL step_counts cyc=%0d ret=%0d exp %0d/%0d", bus.cycle_cnt, bus.retired_cnt, base_c + 3, base_r + 1); end
        // random stall length, with halt_req and a breakpoint match that STEP must ignore
        k = int'($urandom_range(0, 3));
        bus.step_req = 1; bus.halt_req = 1; bus.bp_en = 1; bus.bp_addr = bus.pc_addr;
        tick(); bus.step_req = 0; e_active = 1;
        base_c = e_cyc; base_r = e_ret;
        for (int j = 0; j < k; j++) begin
            bus.hazard_stall = 1; tick();
            checks++; if (bus.state !== ST_STEP) begin
                errors++; $display("FAIL step_rand_hold k=%0d j=%0d state=%0d exp 3", k, j, bus.state); end
        end
        bus.hazard_stall = 0; tick(); e_active = 0;
        checks++; if (bus.state !== ST_HALTED || bus.halt_cause !== 3'd2 || bus.cycle_cnt !== base_c + 32'(k + 1) || bus.retired_cnt !== base_r + 32'd1) begin
            errors++; $display("FAIL step_rand k=%0d state=%0d cause=%0d cyc=%0d ret=%0d exp 1/2/%0d/%0d", k, bus.state, bus.halt_cause, bus.cycle_cnt, bus.retired_cnt, base_c + 32'(k + 1), base_r + 1); end
        bus.halt_req = 0; bus.bp_en = 0;
        bus.step_req = 1; tick(); bus.step_req = 0; e_active = 1;
        bus.hazard_stall = 1; bus.halt_instr = 1; tick(); e_active = 0;
        checks++; if (bus.state !== ST_HALTED || bus.halt_cause !== 3'd6) begin
            errors++; $display("FAIL step_halt_instr state=%0d cause=%0d exp 1/6", bus.state, bus.halt_cause); end
        bus.halt_instr = 0; bus.hazard_stall = 0;
        bus.run_req = 1; bus.step_req = 1; tick(); e_active = 1;
        bus.run_req = 0; bus.step_req = 0;
        checks++; if (bus.state !== ST_RUN || bus.halt_cause !== 3'd0) begin
            errors++; $display("FAIL run_over_step state=%0d cause=%0d exp 2/0", bus.state, bus.halt_cause); end
        bus.pc_addr = 16'h0030; tick();
    endtask

    task automatic test_fault();
        logic [31:0] held_c, held_r;
        bus.div0 = 1; bus.halt_req = 1;
        tick(); e_active = 0;
        bus.div0 = 0; bus.halt_req = 0;
        checks++; if (bus.state !== ST_FAULT || bus.halt_cause !== 3'd4 || bus.freeze !== 1'b1 || bus.core_rst !== 1'b0) begin
            errors++; $display("FAIL fault_div0 state=%0d cause=%0d freeze=%b core_rst=%b exp 4/4/1/0", bus.state, bus.halt_cause, bus.freeze, bus.core_rst); end
        held_c = e_cyc; held_r = e_ret;
        bus.run_req = 1; tick(); bus.run_req = 0;
        bus.step_req = 1; tick(); bus.step_req = 0;
        checks++; if (bus.state !== ST_FAULT || bus.cycle_cnt !== held_c || bus.retired_cnt !== held_r) begin
            errors++; $display("FAIL fault_sticky state=%0d cyc=%0d ret=%0d exp 4/%0d/%0d", bus.state, bus.cycle_cnt, bus.retired_cnt, held_c, held_r); end
        bus.clear_req = 1; tick(); bus.clear_req = 0;
        e_cyc = 0; e_ret = 0;
        checks++; if (bus.state !== ST_RESET_HOLD || bus.core_rst !== 1'b1 || bus.halt_cause !== 3'd4) begin
            errors++; $display("FAIL fault_clear state=%0d core_rst=%b cause=%0d exp 0/1/4", bus.state, bus.core_rst, bus.halt_cause); end
        for (int i = 1; i <= 4; i++) begin
            tick();
            checks++; if (bus.core_rst !== (i < 4)) begin
                errors++; $display("FAIL fault_rehold cycle=%0d core_rst=%b exp %b", i, bus.core_rst, (i < 4)); end
        end
        e_active = 1;
        checks++; if (bus.state !== ST_RUN || bus.halt_cause !== 3'd0 || bus.cycle_cnt !== 32'd0 || bus.retired_cnt !== 32'd0) begin
            errors++; $display("FAIL fault_rerun state=%0d cause=%0d cyc=%0d ret=%0d exp 2/0/0/0", bus.state, bus.halt_cause, bus.cycle_cnt, bus.retired_cnt); end
    endtask

    task automatic test_priority();
        bit d, o, hi, bpm, hr;
        logic [2:0] exp_state, exp_cause;
        for (int it = 0; it < 16; it++) begin
            d   = ($urandom_range(0, 3) == 0);
            o   = ($urandom_range(0, 3) == 0);
            hi  = ($urandom_range(0, 3) == 0);
            bpm = ($urandom_range(0, 2) == 0);
            hr  = ($urandom_range(0, 2) == 0);
            if (d)        begin exp_state = ST_FAULT;  exp_cause = 3'd4; end
            else if (o)   begin exp_state = ST_FAULT;  exp_cause = 3'd5; end
            else if (hi)  begin exp_state = ST_HALTED; exp_cause = 3'd6; end
            else if (bpm) begin exp_state = ST_HALTED; exp_cause = 3'd3; end
            else if (hr)  begin exp_state = ST_HALTED; exp_cause = 3'd1; end
            else          begin exp_state = ST_RUN;    exp_cause = 3'd0; end
            bus.div0 = d; bus.overflow = o; bus.halt_instr = hi; bus.halt_req = hr;
            bus.bp_en = 1; bus.bp_addr = 16'h0010; bus.pc_addr = bpm ? 16'h0010 : 16'h0030;
            bus.hazard_stall = 1'($urandom_range(0, 1));
            tick();
            clear_inputs(); bus.pc_addr = 16'h0030;
            checks++; if (bus.state !== exp_state || bus.halt_cause !== exp_cause) begin
                errors++; $display("FAIL priority it=%0d ev=%b%b%b%b%b state=%0d cause=%0d exp %0d/%0d", it, d, o, hi, bpm, hr, bus.state, bus.halt_cause, exp_state, exp_cause); end
            if (exp_state == ST_FAULT) begin
                e_active = 0;
                bus.clear_req = 1; tick(); bus.clear_req = 0;
                e_cyc = 0; e_ret = 0;
                repeat (4) tick();
                e_active = 1;
            end else if (exp_state == ST_HALTED) begin
                e_active = 0;
                bus.run_req = 1; tick(); bus.run_req = 0;
                e_active = 1;
                tick();
            end
        end
        checks++; if (bus.state !== ST_RUN || bus.cycle_cnt !== e_cyc || bus.retired_cnt !== e_ret) begin
            errors++; $display("FAIL priority_counts state=%0d cyc=%0d ret=%0d exp 2/%0d/%0d", bus.state, bus.cycle_cnt, bus.retired_cnt, e_cyc, e_ret); end
    endtask

    task automatic test_reset_mid_step();
        bus.halt_req = 1; tick(); bus.halt_req = 0; e_active = 0;
        bus.step_req = 1; bus.hazard_stall = 1; tick(); bus.step_req = 0; e_active = 1;
        tick();
        checks++; if (bus.state !== ST_STEP) begin
            errors++; $display("FAIL midstep_setup state=%0d exp 3", bus.state); end
        #3 rst_n = 0;
        #1;
        checks++; if (bus.state !== ST_RESET_HOLD || bus.core_rst !== 1'b1 || bus.freeze !== 1'b1 || bus.halt_cause !== 3'd0 || bus.cycle_cnt !== 32'd0 || bus.retired_cnt !== 32'd0) begin
            errors++; $display("FAIL midstep_reset state=%0d core_rst=%b freeze=%b cause=%0d cyc=%0d ret=%0d exp 0/1/1/0/0/0", bus.state, bus.core_rst, bus.freeze, bus.halt_cause, bus.cycle_cnt, bus.retired_cnt); end
        @(posedge clk); #1;
        clear_inputs(); rst_n = 1; e_active = 0; e_cyc = 0; e_ret = 0;
        repeat (4) tick();
        checks++; if (bus.state !== ST_RUN || bus.core_rst !== 1'b0) begin
            errors++; $display("FAIL midstep_recover state=%0d core_rst=%b exp 2/0", bus.state, bus.core_rst); end
    endtask

    task automatic test_wrap();
        rst4_n = 1;
        repeat (4) begin @(posedge clk); #1; end
        checks++; if (bus4.state !== ST_RUN || bus4.cycle_cnt !== 4'd0) begin
            errors++; $display("FAIL wrap_start state=%0d cyc=%0d exp 2/0", bus4.state, bus4.cycle_cnt); end
        for (int i = 1; i <= 17; i++) begin
            @(posedge clk); #1;
            if (i == 15) begin
                checks++; if (bus4.cycle_cnt !== 4'd15) begin
                    errors++; $display("FAIL wrap_15 cyc=%0d exp 15", bus4.cycle_cnt); end
            end
            if (i == 16) begin
                checks++; if (bus4.cycle_cnt !== 4'd0 || bus4.retired_cnt !== 4'd0) begin
                    errors++; $display("FAIL wrap_16 cyc=%0d ret=%0d exp 0/0", bus4.cycle_cnt, bus4.retired_cnt); end
            end
        end
        checks++; if (bus4.cycle_cnt !== 4'd1 || bus4.retired_cnt !== 4'd1) begin
            errors++; $display("FAIL wrap_17 cyc=%0d ret=%0d exp 1/1", bus4.cycle_cnt, bus4.retired_cnt); end
    endtask

    initial begin
        bus4.run_req = 0; bus4.step_req = 0; bus4.halt_req = 0; bus4.clear_req = 0;
        bus4.bp_en = 0; bus4.bp_addr = 16'h0000; bus4.pc_addr = 16'h0100;
        bus4.hazard_stall = 0; bus4.halt_instr = 0; bus4.div0 = 0; bus4.overflow = 0;
        clear_inputs();
        test_reset();
        test_breakpoint();
        test_step();
        test_fault();
        test_priority();
        test_reset_mid_step();
        test_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end

endmodule
